// File: rtl/imem_arbiter.sv
// imem_arbiter: shares the dual-read-port instruction BRAM between fetch and the loader/debug port.
// Fetch has priority; a starvation limit and a lock mode guarantee the loader makes progress.
module imem_arbiter #(
  parameter int unsigned PC_W     = 32,
  parameter int unsigned INSTR_W  = 32,
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  // fetch port
  input  logic               f_ren,
  input  logic [PC_W-1:0]    f_addr0,
  input  logic [PC_W-1:0]    f_addr1,
  output logic               f_gnt,
  output logic               f_rvalid,
  output logic [INSTR_W-1:0] f_rdata0,
  output logic [INSTR_W-1:0] f_rdata1,
  // loader / debug port
  input  logic               ld_req,
  input  logic               ld_we,
  input  logic               ld_lock,
  input  logic [PC_W-1:0]    ld_addr,
  input  logic [INSTR_W-1:0] ld_wdata,
  output logic               ld_gnt,
  output logic               ld_rvalid,
  output logic [INSTR_W-1:0] ld_rdata,
  // instruction memory
  output logic               mem_en,
  output logic               mem_we,
  output logic [PC_W-1:0]    mem_addr0,
  output logic [PC_W-1:0]    mem_addr1,
  output logic [INSTR_W-1:0] mem_wdata,
  input  logic [INSTR_W-1:0] mem_rdata0,
  input  logic [INSTR_W-1:0] mem_rdata1,
  // statistics
  output logic [CNT_W-1:0]   conflict_cnt
);

  localparam int unsigned       WAIT_W   = 4;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0]  CNT_SAT  = '1;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_LOCK = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE   = 2'd0,
    OWN_FETCH  = 2'd1,
    OWN_LDREAD = 2'd2
  } own_e;

  state_e             state_q, state_d;
  own_e               own_q, own_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]   conflict_cnt_q, conflict_cnt_d;

  // State, counters and response owner; reset is synchronous and active-low.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= ST_RUN;
      own_q          <= OWN_NONE;
      wait_cnt_q     <= '0;
      conflict_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      own_q          <= own_d;
      wait_cnt_q     <= wait_cnt_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  // Arbitration, next state and counter updates.
  always_comb begin
    f_gnt          = 1'b0;
    ld_gnt         = 1'b0;
    state_d        = state_q;
    own_d          = OWN_NONE;
    wait_cnt_d     = '0;
    conflict_cnt_d = conflict_cnt_q;

    if (reset) begin
      if (state_q == ST_LOCK) begin
        ld_gnt = ld_req;
      end else if (ld_req && (wait_cnt_q == WAIT_MAX)) begin
        ld_gnt = 1'b1;
      end else begin
        f_gnt  = f_ren;
        ld_gnt = ld_req & ~f_ren;
      end

      state_d = ld_lock ? ST_LOCK : ST_RUN;

      if (f_gnt) begin
        own_d = OWN_FETCH;
      end else if (ld_gnt && !ld_we) begin
        own_d = OWN_LDREAD;
      end

      // Starvation counter only runs while the loader is asking and losing.
      if (ld_req && !ld_gnt) begin
        wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);
      end

      if (f_ren && !f_gnt && (conflict_cnt_q != CNT_SAT)) begin
        conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
      end
    end
  end

  // Memory request mux; idle cycles drive zeros.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr0 = '0;
    mem_addr1 = '0;
    mem_wdata = '0;
    if (f_gnt) begin
      mem_en    = 1'b1;
      mem_addr0 = f_addr0;
      mem_addr1 = f_addr1;
    end else if (ld_gnt) begin
      mem_en    = 1'b1;
      mem_we    = ld_we;
      mem_addr0 = ld_addr;
      mem_addr1 = ld_addr;
      mem_wdata = ld_wdata;
    end
  end

  // Read data is steered by the owner tag captured one cycle earlier.
  assign f_rvalid     = (own_q == OWN_FETCH);
  assign ld_rvalid    = (own_q == OWN_LDREAD);
  assign f_rdata0     = mem_rdata0;
  assign f_rdata1     = mem_rdata1;
  assign ld_rdata     = mem_rdata0;
  assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: vector table, corner-case sequences and a random run against a reference model.
module tb_imem_arbiter;

  localparam int unsigned PC_W      = 32;
  localparam int unsigned INSTR_W   = 32;
  localparam int unsigned MAX_WAIT  = 4;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned MEM_WORDS = 64;
  localparam int unsigned CNT_MAX   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n, f_ren, ld_req, ld_we, ld_lock, preload;
  logic [PC_W-1:0]    fa0, fa1, la;
  logic [INSTR_W-1:0] wd;
  logic               f_gnt, f_rvalid, ld_gnt, ld_rvalid, mem_en, mem_we;
  logic [INSTR_W-1:0] f_rdata0, f_rdata1, ld_rdata, mem_wdata, mem_rdata0, mem_rdata1;
  logic [PC_W-1:0]    mem_addr0, mem_addr1;
  logic [CNT_W-1:0]   conflict_cnt;

  imem_arbiter #(.PC_W(PC_W), .INSTR_W(INSTR_W), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(rst_n),
    .f_ren(f_ren), .f_addr0(fa0), .f_addr1(fa1), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
    .f_rdata0(f_rdata0), .f_rdata1(f_rdata1),
    .ld_req(ld_req), .ld_we(ld_we), .ld_lock(ld_lock), .ld_addr(la), .ld_wdata(wd),
    .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr0(mem_addr0), .mem_addr1(mem_addr1),
    .mem_wdata(mem_wdata), .mem_rdata0(mem_rdata0), .mem_rdata1(mem_rdata1),
    .conflict_cnt(conflict_cnt)
  );

  function automatic logic [INSTR_W-1:0] init_word(input int i);
    case (i)
      0:       return 32'h1111_1111;
      1:       return 32'h2222_2222;
      4:       return 32'h5555_5555;
      default: return 32'hC000_0000 | 32'(i);
    endcase
  endfunction

  // 1-cycle-latency synchronous BRAM, read-before-write
  logic [INSTR_W-1:0] bram [MEM_WORDS];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < int'(MEM_WORDS); i++) bram[i] <= init_word(i);
    end else if (mem_en) begin
      mem_rdata0 <= bram[mem_addr0[7:2]];
      mem_rdata1 <= bram[mem_addr1[7:2]];
      if (mem_we) bram[mem_addr0[7:2]] <= mem_wdata;
    end
  end

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: transaction-level view of the arbitration rules
  logic [INSTR_W-1:0] ref_mem [MEM_WORDS];
  bit                 m_lock;
  int unsigned        m_wait, m_cnt;
  int                 m_own;            // 0 none, 1 fetch, 2 loader read
  logic [INSTR_W-1:0] m_d0, m_d1;
  logic               e_fg, e_lg, e_en, e_we;
  logic [PC_W-1:0]    e_a0, e_a1;

  task automatic model_comb();
    e_fg = 1'b0;
    e_lg = 1'b0;
    if (rst_n) begin
      if (m_lock) e_lg = ld_req;
      else if (ld_req && m_wait >= MAX_WAIT) e_lg = 1'b1;
      else begin
        e_fg = f_ren;
        e_lg = ld_req && !f_ren;
      end
    end
    e_en = e_fg || e_lg;
    e_we = e_lg && ld_we;
    e_a0 = e_fg ? fa0 : (e_lg ? la : '0);
    e_a1 = e_fg ? fa1 : (e_lg ? la : '0);
  endtask

  task automatic model_tick();
    if (!rst_n) begin
      m_lock = 1'b0; m_wait = 0; m_own = 0; m_cnt = 0;
    end else begin
      if (e_fg) begin
        m_own = 1; m_d0 = ref_mem[fa0[7:2]]; m_d1 = ref_mem[fa1[7:2]];
      end else if (e_lg && !ld_we) begin
        m_own = 2; m_d0 = ref_mem[la[7:2]];
      end else m_own = 0;
      if (e_lg && ld_we) ref_mem[la[7:2]] = wd;
      if (ld_req && !e_lg) m_wait = (m_wait + 1 > MAX_WAIT) ? MAX_WAIT : m_wait + 1;
      else m_wait = 0;
      if (f_ren && !e_fg && m_cnt < CNT_MAX) m_cnt++;
      m_lock = ld_lock;
    end
  endtask

  task automatic check_model();
    model_comb();
    chk("f_gnt", 64'(f_gnt), 64'(e_fg));
    chk("ld_gnt", 64'(ld_gnt), 64'(e_lg));
    chk("mem_en", 64'(mem_en), 64'(e_en));
    chk("mem_we", 64'(mem_we), 64'(e_we));
    chk("mem_addr0", 64'(mem_addr0), 64'(e_a0));
    chk("mem_addr1", 64'(mem_addr1), 64'(e_a1));
    if (e_we) chk("mem_wdata", 64'(mem_wdata), 64'(wd));
    else if (!e_en) chk("mem_wdata_idle", 64'(mem_wdata), 64'd0);
    chk("f_rvalid", 64'(f_rvalid), 64'(m_own == 1));
    chk("ld_rvalid", 64'(ld_rvalid), 64'(m_own == 2));
    if (m_own == 1) begin
      chk("f_rdata0", 64'(f_rdata0), 64'(m_d0));
      chk("f_rdata1", 64'(f_rdata1), 64'(m_d1));
    end
    if (m_own == 2) chk("ld_rdata", 64'(ld_rdata), 64'(m_d0));
    chk("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));
  endtask

  task automatic tick();
    @(posedge clk);
    model_comb();
    model_tick();
    #1;
  endtask

  task automatic step();
    @(negedge clk);
    check_model();
    tick();
  endtask

  task automatic idle_inputs();
    f_ren = 0; ld_req = 0; ld_we = 0; ld_lock = 0;
    fa0 = '0; fa1 = '0; la = '0; wd = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        rst_n, f_ren, ld_req, ld_we;
    logic [31:0] fa0, fa1, la;
    logic        e_fg, e_lg, e_frv, e_lrv;
    logic [31:0] e_d0, e_d1;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t vt [14];

  localparam logic [31:0] W0 = 32'h1111_1111;
  localparam logic [31:0] W1 = 32'h2222_2222;
  localparam logic [31:0] W4 = 32'h5555_5555;

  bit lk;

  initial begin
    idle_inputs();
    rst_n   = 1'b0;
    preload = 1'b1;
    for (int i = 0; i < int'(MEM_WORDS); i++) ref_mem[i] = init_word(i);
    m_lock = 0; m_wait = 0; m_own = 0; m_cnt = 0; m_d0 = '0; m_d1 = '0;
    tick();
    tick();
    preload = 1'b0;

    // reset release, plain fetch, then fetch vs loader starvation pattern
    vt[0]  = '{0,1,0,0, 0,4,0,     0,0,0,0, 0,0,   0};
    vt[1]  = '{1,1,0,0, 0,4,0,     1,0,0,0, 0,0,   0};
    vt[2]  = '{1,1,0,0, 0,4,0,     1,0,1,0, W0,W1, 0};
    for (int i = 3; i <= 6; i++)
      vt[i] = '{1,1,1,0, 0,4,32'h10, 1,0,1,0, W0,W1, 0};
    vt[7]  = '{1,1,1,0, 0,4,32'h10, 0,1,1,0, W0,W1, 0};
    vt[8]  = '{1,1,1,0, 0,4,32'h10, 1,0,0,1, W4,0,  1};
    for (int i = 9; i <= 11; i++)
      vt[i] = '{1,1,1,0, 0,4,32'h10, 1,0,1,0, W0,W1, 1};
    vt[12] = '{1,1,1,0, 0,4,32'h10, 0,1,1,0, W0,W1, 1};
    vt[13] = '{1,0,0,0, 0,4,32'h10, 0,0,0,1, W4,0,  2};

    for (int i = 0; i < 14; i++) begin
      rst_n = vt[i].rst_n; f_ren = vt[i].f_ren; ld_req = vt[i].ld_req; ld_we = vt[i].ld_we;
      fa0 = vt[i].fa0; fa1 = vt[i].fa1; la = vt[i].la;
      @(negedge clk);
      chk($sformatf("tbl%0d_f_gnt", i), 64'(f_gnt), 64'(vt[i].e_fg));
      chk($sformatf("tbl%0d_ld_gnt", i), 64'(ld_gnt), 64'(vt[i].e_lg));
      chk($sformatf("tbl%0d_mem_en", i), 64'(mem_en), 64'(vt[i].e_fg | vt[i].e_lg));
      chk($sformatf("tbl%0d_f_rvalid", i), 64'(f_rvalid), 64'(vt[i].e_frv));
      chk($sformatf("tbl%0d_ld_rvalid", i), 64'(ld_rvalid), 64'(vt[i].e_lrv));
      if (vt[i].e_frv) begin
        chk($sformatf("tbl%0d_f_rdata0", i), 64'(f_rdata0), 64'(vt[i].e_d0));
        chk($sformatf("tbl%0d_f_rdata1", i), 64'(f_rdata1), 64'(vt[i].e_d1));
      end
      if (vt[i].e_lrv) chk($sformatf("tbl%0d_ld_rdata", i), 64'(ld_rdata), 64'(vt[i].e_d0));
      chk($sformatf("tbl%0d_conflict", i), 64'(conflict_cnt), 64'(vt[i].e_cnt));
      tick();
    end

    // lock burst write with a fetch in flight at lock entry, then read back
    do_reset();
    f_ren = 1; fa0 = 32'h8; fa1 = 32'hC;
    ld_lock = 1; ld_req = 1; ld_we = 1; la = 32'h8; wd = 32'hDEAD_BEEF;
    @(negedge clk);
    check_model();
    chk("lk_fetch_first", 64'(f_gnt), 64'd1);
    tick();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_model();
      if (k == 0) begin
        chk("lk_inflight_rvalid", 64'(f_rvalid), 64'd1);
        chk("lk_inflight_data", 64'(f_rdata0), 64'(init_word(2)));
      end
      chk("lk_fetch_denied", 64'(f_gnt), 64'd0);
      chk("lk_mem_we", 64'(mem_we), 64'd1);
      tick();
    end
    ld_lock = 0; ld_req = 0; ld_we = 0;
    step();
    step();
    @(negedge clk);
    check_model();
    chk("lk_readback_valid", 64'(f_rvalid), 64'd1);
    chk("lk_readback_data", 64'(f_rdata0), 64'hDEAD_BEEF);
    chk("lk_conflicts", 64'(conflict_cnt), 64'd4);
    tick();

    // reset right after a fetch grant discards the response
    do_reset();
    f_ren = 1; fa0 = 32'h0; fa1 = 32'h4;
    step();
    rst_n = 0;
    @(negedge clk);
    check_model();
    chk("rs_f_gnt_forced", 64'(f_gnt), 64'd0);
    chk("rs_mem_en_forced", 64'(mem_en), 64'd0);
    tick();
    @(negedge clk);
    check_model();
    chk("rs_no_rvalid", 64'(f_rvalid), 64'd0);
    chk("rs_no_ld_rvalid", 64'(ld_rvalid), 64'd0);
    chk("rs_cnt_zero", 64'(conflict_cnt), 64'd0);
    tick();
    rst_n = 1;

    // lock with no loader request: memory idles, fetch denied, counter saturates
    do_reset();
    f_ren = 1; fa0 = 32'h0; fa1 = 32'h4; ld_lock = 1;
    step();
    for (int k = 0; k < 20; k++) step();
    @(negedge clk);
    check_model();
    chk("sat_cnt", 64'(conflict_cnt), 64'(CNT_MAX));
    chk("sat_mem_idle", 64'(mem_en), 64'd0);
    chk("sat_f_denied", 64'(f_gnt), 64'd0);
    tick();

    // randomized traffic against the reference model
    do_reset();
    lk = 1'b0;
    for (int k = 0; k < 400; k++) begin
      rst_n  = ($urandom_range(0, 49) != 0);
      f_ren  = ($urandom_range(0, 3) != 0);
      ld_req = 1'($urandom_range(0, 1));
      ld_we  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) lk = ~lk;
      ld_lock = lk;
      fa0 = 32'($urandom_range(0, 63)) << 2;
      fa1 = 32'($urandom_range(0, 63)) << 2;
      la  = 32'($urandom_range(0, 63)) << 2;
      wd  = $urandom;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Shares the single dual-read-port instruction BRAM between the front-end fetch unit and the program loader/debug port. Fetch has priority, but a starvation limit guarantees loader progress, and a lock mode gives the loader exclusive access for burst program loads. The block sits between the fetch stage and the 1-cycle-latency synchronous instruction memory, and tags each read so its data is returned to the correct requester one cycle later.

## Interface
- PC_W, 32, address width of both requesters and the memory.
- INSTR_W, 32, instruction/data width.
- MAX_WAIT, 4, consecutive denied loader cycles before the loader is forced a grant; range 1..15.
- CNT_W, 16, width of the conflict counter.

- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge).
- f_ren  in  1  fetch read request, two words.
- f_addr0 / f_addr1  in  PC_W  fetch byte addresses, slot 0 and slot 1.
- f_gnt  out  1  fetch granted this cycle; when 0, fetch must hold its PC (treated as stall).
- f_rvalid  out  1  fetch read data valid.
- f_rdata0 / f_rdata1  out  INSTR_W  fetch read data.
- ld_req  in  1  loader access request.
- ld_we  in  1  loader write (1) or read (0).
- ld_lock  in  1  loader requests exclusive ownership.
- ld_addr  in  PC_W  loader byte address.
- ld_wdata  in  INSTR_W  loader write data.
- ld_gnt  out  1  loader granted this cycle.
- ld_rvalid  out  1  loader read data valid.
- ld_rdata  out  INSTR_W  loader read data.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable (port 0 only).
- mem_addr0 / mem_addr1  out  PC_W  memory addresses.
- mem_wdata  out  INSTR_W  memory write data.
- mem_rdata0 / mem_rdata1  in  INSTR_W  memory read data, valid 1 cycle after mem_en.
- conflict_cnt  out  CNT_W  saturating count of cycles in which f_ren=1 and f_gnt=0.

## Operation
- State machine, two states:
  - RUN: normal arbitration.
  - LOCK: loader has exclusive access.
- RUN -> LOCK on a cycle with ld_lock=1; the transition takes effect at the next edge.
- LOCK -> RUN on a cycle with ld_lock=0; the transition takes effect at the next edge.
- Grant rules, combinational from requests and registered state:
  - In LOCK: f_gnt=0; ld_gnt=ld_req.
  - In RUN with wait_cnt==MAX_WAIT and ld_req=1: ld_gnt=1, f_gnt=0 (forced loader grant).
  - Otherwise in RUN: f_gnt=f_ren; ld_gnt=ld_req & ~f_ren.
  - Grants are mutually exclusive.
- wait_cnt (4-bit):
  - Increments when ld_req=1 and ld_gnt=0.
  - Clears when ld_gnt=1 or ld_req=0.
  - Never exceeds MAX_WAIT.
- Memory mux:
  - On a fetch grant: mem_en=1, mem_we=0, addresses are f_addr0/f_addr1.
  - On a loader grant: mem_en=1, mem_we=ld_we, mem_addr0=mem_addr1=ld_addr, mem_wdata=ld_wdata.
  - With no grant: mem_en=0, mem_we=0, addresses and wdata are 0.
- Response tagging: register own_q ∈ {NONE, FETCH, LDREAD} captures the granted read each cycle. Loader writes tag NONE.
  - f_rvalid = (own_q==FETCH); f_rdata0/1 = mem_rdata0/1.
  - ld_rvalid = (own_q==LDREAD); ld_rdata = mem_rdata0.
  - rdata outputs pass through unconditionally; consumers qualify them with the valid signal.
- conflict_cnt increments on each cycle with f_ren=1 and f_gnt=0, and saturates at all-ones.

## Timing
- Reset (reset=0 at an edge) sets:
  - state=RUN, wait_cnt=0, own_q=NONE, conflict_cnt=0.
  - Hence f_rvalid=0 and ld_rvalid=0.
- While reset=0:
  - f_gnt, ld_gnt, mem_en and mem_we are forced to 0.
  - conflict_cnt does not count.
- Grant latency is 0 cycles (same cycle as the request). Read data latency is exactly 1 cycle after the grant. There is no backpressure on responses.
- A read already in flight when a LOCK entry or a reset occurs:
  - Lock entry: the in-flight response is still delivered to its owner the next cycle.
  - Reset: the in-flight response is discarded (own_q is cleared).
- ld_lock asserted with ld_req=0: the memory idles (mem_en=0) and fetch stays denied.
- Simultaneous f_ren and ld_req with wait_cnt<MAX_WAIT: fetch wins and wait_cnt increments.

## Test plan
- Reset release, f_ren=1 every cycle, f_addr0=0x00/f_addr1=0x04, memory preloaded with 0x11111111/0x22222222 -> f_gnt=1 in the same cycle; f_rvalid=1 with rdata 0x11111111/0x22222222 one cycle later; conflict_cnt=0.
- f_ren=1 and ld_req=1 (read of 0x10) held continuously, MAX_WAIT=4:
  - Fetch is granted for 4 cycles.
  - On the 5th cycle ld_gnt=1 and f_gnt=0.
  - The next cycle ld_rvalid=1 with ld_rdata=0x55555555; conflict_cnt=1.
  - The pattern then repeats (4 fetch grants, 1 loader grant).
- ld_lock=1, ld_req=1, ld_we=1, ld_addr=0x08, ld_wdata=0xDEADBEEF, with f_ren=1:
  - After the LOCK transition f_gnt=0 and mem_we=1.
  - After ld_lock drops, fetch from 0x08 returns 0xDEADBEEF.
  - conflict_cnt equals the number of locked cycles.
- Fetch read granted in cycle N, ld_lock asserted in cycle N -> f_rvalid=1 in cycle N+1 with correct data; from cycle N+1 only the loader is granted.
- reset=0 asserted one cycle after a fetch grant -> no f_rvalid; all counters and outputs at their reset values.
- Force conflict_cnt near saturation (CNT_W=4, 20 denied cycles) -> holds at 0xF.
